// File: rtl/uart_core_cfg.sv
// uart_core_cfg: full-duplex UART with configurable framing and oversampled, majority-voted RX
module uart_core_cfg #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int OVERSAMPLE      = 16
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_valid_in,
    output logic                 tx_ready_out,
    output logic                 tx_serial_out,
    output logic                 tx_done_out,
    input  logic                 rx_serial_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid_out,
    output logic                 rx_parity_err_out,
    output logic                 rx_frame_err_out
);
    localparam int OS_RAW = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int OS_DIV = OS_RAW < 1 ? 1 : OS_RAW;
    localparam int BIT_CLKS = OVERSAMPLE * OS_DIV;
    localparam int DW = $clog2(OS_DIV + 1);
    localparam int CW = $clog2(BIT_CLKS + 1);
    localparam int OW = $clog2(OVERSAMPLE + 1);
    localparam int H = OVERSAMPLE / 2;
    localparam logic HAS_PAR = PARITY != 0;
    localparam logic ODD = PARITY == 1;

    logic [DW-1:0] div_cnt;
    logic os_tick;
    assign os_tick = div_cnt == DW'(OS_DIV - 1);
    always_ff @(posedge clk)
        div_cnt <= (rst_in || os_tick) ? '0 : div_cnt + 1'b1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    tx_state_t tx_state, tx_next;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [3:0] tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic tx_par, tx_par_n, tx_line, tx_line_n, tx_bit_end;

    assign tx_bit_end = tx_cnt == CW'(BIT_CLKS - 1);
    assign tx_ready_out = tx_state == TX_IDLE && !rst_in;
    assign tx_done_out = tx_state == TX_STOP && tx_bit_end && tx_idx == 4'(STOP_BITS - 1);
    assign tx_serial_out = tx_line;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_line  <= tx_line_n;
        end
    end

    // tx_line is registered one step ahead so the pin changes exactly on bit boundaries
    always_comb begin
        tx_next    = tx_state;
        tx_cnt_n   = tx_bit_end ? '0 : tx_cnt + 1'b1;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_line_n  = tx_line;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_valid_in && tx_ready_out) begin
                    tx_next    = TX_START;
                    tx_shift_n = tx_data_in;
                    tx_par_n   = (^tx_data_in) ^ ODD;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: if (tx_bit_end) begin
                tx_next   = TX_DATA;
                tx_idx_n  = '0;
                tx_line_n = tx_shift[0];
            end
            TX_DATA: if (tx_bit_end) begin
                if (tx_idx == 4'(DATA_BITS - 1)) begin
                    tx_next   = HAS_PAR ? TX_PAR : TX_STOP;
                    tx_idx_n  = '0;
                    tx_line_n = HAS_PAR ? tx_par : 1'b1;
                end else begin
                    tx_idx_n   = tx_idx + 1'b1;
                    tx_shift_n = tx_shift >> 1;
                    tx_line_n  = tx_shift[1];
                end
            end
            TX_PAR: if (tx_bit_end) begin
                tx_next   = TX_STOP;
                tx_idx_n  = '0;
                tx_line_n = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                tx_next  = tx_done_out ? TX_IDLE : TX_STOP;
                tx_idx_n = tx_idx + 1'b1;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    rx_state_t rx_state, rx_next;
    logic [1:0] rx_sync;
    logic rx_s, rx_prev;
    logic [OW-1:0] os_cnt, os_cnt_n;
    logic [3:0] rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic s0, s1, s0_n, s1_n, rx_perr, rx_perr_n;
    logic maj, resolve, rx_bit_end, deliver;

    assign rx_s = rx_sync[1];
    assign maj = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign resolve = os_tick && os_cnt == OW'(H);
    assign rx_bit_end = os_tick && os_cnt == OW'(OVERSAMPLE - 1);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rx_state          <= RX_IDLE;
            rx_sync           <= 2'b11;
            rx_prev           <= 1'b1;
            os_cnt            <= '0;
            rx_idx            <= '0;
            rx_shift          <= '0;
            s0                <= 1'b1;
            s1                <= 1'b1;
            rx_perr           <= 1'b0;
            rx_data_out       <= '0;
            rx_valid_out      <= 1'b0;
            rx_parity_err_out <= 1'b0;
            rx_frame_err_out  <= 1'b0;
        end else begin
            rx_state     <= rx_next;
            rx_sync      <= {rx_sync[0], rx_serial_in};
            rx_prev      <= rx_s;
            os_cnt       <= os_cnt_n;
            rx_idx       <= rx_idx_n;
            rx_shift     <= rx_shift_n;
            s0           <= s0_n;
            s1           <= s1_n;
            rx_perr      <= rx_perr_n;
            rx_valid_out <= deliver;
            if (deliver) begin
                rx_data_out       <= rx_shift;
                rx_parity_err_out <= rx_perr;
                rx_frame_err_out  <= !maj;
            end
        end
    end

    // s0/s1 hold the first two votes; the third is the live sample at the resolve tick
    always_comb begin
        rx_next    = rx_state;
        os_cnt_n   = rx_bit_end ? '0 : os_cnt + OW'(os_tick);
        s0_n       = (os_tick && os_cnt == OW'(H - 2)) ? rx_s : s0;
        s1_n       = (os_tick && os_cnt == OW'(H - 1)) ? rx_s : s1;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_perr_n  = rx_perr;
        deliver    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                os_cnt_n = '0;
                if (rx_prev && !rx_s) begin
                    rx_next   = RX_START;
                    rx_perr_n = 1'b0;
                end
            end
            RX_START: begin
                if (resolve && maj)
                    rx_next = RX_IDLE;
                else if (rx_bit_end) begin
                    rx_next  = RX_DATA;
                    rx_idx_n = '0;
                end
            end
            RX_DATA: begin
                if (resolve)
                    rx_shift_n = {maj, rx_shift[DATA_BITS-1:1]};
                if (rx_bit_end) begin
                    rx_idx_n = rx_idx + 1'b1;
                    if (rx_idx == 4'(DATA_BITS - 1))
                        rx_next = HAS_PAR ? RX_PAR : RX_STOP;
                end
            end
            RX_PAR: begin
                if (resolve)
                    rx_perr_n = maj ^ (^rx_shift) ^ ODD;
                if (rx_bit_end)
                    rx_next = RX_STOP;
            end
            RX_STOP: if (resolve) begin
                deliver = 1'b1;
                rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_core_cfg.sv
// tb_uart_core_cfg: randomized loopback and bench-driven frame checks against a bit-list frame model
`timescale 1ns/1ps
module tb_uart_core_cfg;
    localparam int FAST_CLK = 7_372_800;
    localparam int BC = 64;
    localparam int BC_S = 864;

    typedef struct packed {
        logic [1:0] id;
        logic pe;
        logic fe;
        logic [8:0] d;
    } rx_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_valid[4], tx_ready[4], tx_ser[4], tx_done[4];
    logic rx_line[4], rx_valid[4], rx_perr[4], rx_ferr[4], loop[4], drv[4];
    logic [7:0] td8[3], rd8[3];
    logic [6:0] td7, rd7;
    logic [8:0] rx_data[4];
    logic fb[$];
    rx_ev_t rxq[$];
    logic [7:0] words[16];
    int acc_t[16];
    int cyc = 0;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_data[0] = {1'b0, rd8[0]};
    assign rx_data[1] = {1'b0, rd8[1]};
    assign rx_data[2] = {1'b0, rd8[2]};
    assign rx_data[3] = {2'b0, rd7};

    always_comb
        for (int i = 0; i < 4; i++) rx_line[i] = loop[i] ? tx_ser[i] : drv[i];

    uart_core_cfg #(.CLOCK_FREQUENCY(FAST_CLK), .PARITY(0)) u_n (
        .clk(clk), .rst_in(rst), .tx_data_in(td8[0]), .tx_valid_in(tx_valid[0]),
        .tx_ready_out(tx_ready[0]), .tx_serial_out(tx_ser[0]), .tx_done_out(tx_done[0]),
        .rx_serial_in(rx_line[0]), .rx_data_out(rd8[0]), .rx_valid_out(rx_valid[0]),
        .rx_parity_err_out(rx_perr[0]), .rx_frame_err_out(rx_ferr[0]));
    uart_core_cfg #(.CLOCK_FREQUENCY(FAST_CLK), .PARITY(2)) u_e (
        .clk(clk), .rst_in(rst), .tx_data_in(td8[1]), .tx_valid_in(tx_valid[1]),
        .tx_ready_out(tx_ready[1]), .tx_serial_out(tx_ser[1]), .tx_done_out(tx_done[1]),
        .rx_serial_in(rx_line[1]), .rx_data_out(rd8[1]), .rx_valid_out(rx_valid[1]),
        .rx_parity_err_out(rx_perr[1]), .rx_frame_err_out(rx_ferr[1]));
    uart_core_cfg #(.CLOCK_FREQUENCY(FAST_CLK), .PARITY(1)) u_o (
        .clk(clk), .rst_in(rst), .tx_data_in(td8[2]), .tx_valid_in(tx_valid[2]),
        .tx_ready_out(tx_ready[2]), .tx_serial_out(tx_ser[2]), .tx_done_out(tx_done[2]),
        .rx_serial_in(rx_line[2]), .rx_data_out(rd8[2]), .rx_valid_out(rx_valid[2]),
        .rx_parity_err_out(rx_perr[2]), .rx_frame_err_out(rx_ferr[2]));
    uart_core_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_s (
        .clk(clk), .rst_in(rst), .tx_data_in(td7), .tx_valid_in(tx_valid[3]),
        .tx_ready_out(tx_ready[3]), .tx_serial_out(tx_ser[3]), .tx_done_out(tx_done[3]),
        .rx_serial_in(rx_line[3]), .rx_data_out(rd7), .rx_valid_out(rx_valid[3]),
        .rx_parity_err_out(rx_perr[3]), .rx_frame_err_out(rx_ferr[3]));

    always @(negedge clk)
        for (int i = 0; i < 4; i++)
            if (!rst && rx_valid[i] === 1'b1)
                rxq.push_back('{2'(i), rx_perr[i], rx_ferr[i], rx_data[i]});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line levels of one frame: start, data LSB first, optional parity, stop bits
    function automatic void make_frame(input logic [8:0] w, input int db, input int par, input int sb);
        int ones = 0;
        fb.delete();
        fb.push_back(1'b0);
        for (int k = 0; k < db; k++) begin
            fb.push_back(w[k]);
            ones += int'(w[k]);
        end
        if (par != 0) fb.push_back(par == 2 ? ones % 2 == 1 : ones % 2 == 0);
        for (int k = 0; k < sb; k++) fb.push_back(1'b1);
    endfunction

    task automatic drive_frame(input int i, input int bc);
        foreach (fb[k]) begin
            drv[i] = fb[k];
            repeat (bc) @(negedge clk);
        end
        drv[i] = 1'b1;
    endtask

    task automatic expect_rx(input int id, input logic [8:0] d, input logic pe, input logic fe, input string tag);
        int n = 0;
        rx_ev_t e;
        while (rxq.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_got"}, rxq.size() != 0, 1);
        if (rxq.size() == 0) return;
        e = rxq.pop_front();
        check({tag, "_id"}, e.id, id);
        check({tag, "_data"}, e.d, d);
        check({tag, "_perr"}, e.pe, pe);
        check({tag, "_ferr"}, e.fe, fe);
    endtask

    task automatic tx_frame(input int i, input logic [8:0] w, input int db, input int par, input int sb, input int bc, input string tag);
        int n = 0;
        int nb, done_at;
        make_frame(w, db, par, sb);
        nb = fb.size();
        if (i == 3) td7 = w[6:0];
        else td8[i] = w[7:0];
        tx_valid[i] = 1'b1;
        while (tx_ready[i] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, tx_ready[i], 1);
        @(posedge clk);
        done_at = 0;
        for (int c = 1; c <= nb * bc + 4 && done_at == 0; c++) begin
            @(negedge clk);
            tx_valid[i] = 1'b0;
            if ((c - 1) % bc == bc / 2)
                check($sformatf("%s_bit%0d", tag, (c - 1) / bc), tx_ser[i], fb[(c - 1) / bc]);
            if (tx_done[i] === 1'b1) done_at = c;
        end
        check({tag, "_len"}, done_at, nb * bc);
    endtask

    task automatic t1_drive();
        int n;
        tx_valid[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            td8[0] = words[k];
            n = 0;
            while (tx_ready[0] !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("t1_rdy", tx_ready[0], 1);
            @(posedge clk);
            @(negedge clk);
            acc_t[k] = cyc;
        end
        tx_valid[0] = 1'b0;
    endtask

    task automatic t1_recv();
        for (int k = 0; k < 16; k++) expect_rx(0, {1'b0, words[k]}, 1'b0, 1'b0, $sformatf("t1_w%0d", k));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            tx_valid[i] = 1'b0;
            drv[i] = 1'b1;
            loop[i] = 1'b1;
        end
        for (int i = 0; i < 3; i++) td8[i] = '0;
        td7 = '0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_ser%0d", i), tx_ser[i], 1);
            check($sformatf("rst_rdy%0d", i), tx_ready[i], 0);
            check($sformatf("rst_done%0d", i), tx_done[i], 0);
            check($sformatf("rst_val%0d", i), rx_valid[i], 0);
            check($sformatf("rst_data%0d", i), rx_data[i], 0);
            check($sformatf("rst_err%0d", i), {rx_perr[i], rx_ferr[i]}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", tx_ready[0], 1);

        for (int k = 0; k < 16; k++) words[k] = 8'($urandom);
        fork
            t1_drive();
            t1_recv();
        join
        for (int k = 1; k < 16; k++) check($sformatf("t1_gap%0d", k), acc_t[k] - acc_t[k - 1], 10 * BC + 1);

        tx_frame(1, 9'h0A5, 8, 2, 1, BC, "t2e");
        expect_rx(1, 9'h0A5, 1'b0, 1'b0, "t2e_rx");
        tx_frame(2, 9'h0A5, 8, 1, 1, BC, "t2o");
        expect_rx(2, 9'h0A5, 1'b0, 1'b0, "t2o_rx");

        loop[1] = 1'b0;
        make_frame(9'h03C, 8, 2, 1);
        fb[9] = !fb[9];
        drive_frame(1, BC);
        expect_rx(1, 9'h03C, 1'b1, 1'b0, "t3");

        loop[0] = 1'b0;
        make_frame(9'h055, 8, 0, 1);
        fb[9] = 1'b0;
        drive_frame(0, BC);
        expect_rx(0, 9'h055, 1'b0, 1'b1, "t4_bad");
        repeat (BC) @(negedge clk);
        make_frame(9'h012, 8, 0, 1);
        drive_frame(0, BC);
        expect_rx(0, 9'h012, 1'b0, 1'b0, "t4_ok");

        repeat (BC) @(negedge clk);
        drv[0] = 1'b0;
        repeat (12) @(negedge clk);
        drv[0] = 1'b1;
        repeat (2 * BC) @(negedge clk);
        check("t5_none", rxq.size(), 0);
        make_frame(9'h081, 8, 0, 1);
        drive_frame(0, BC);
        expect_rx(0, 9'h081, 1'b0, 1'b0, "t5");

        loop[0] = 1'b1;
        repeat (BC) @(negedge clk);
        check("t6_rdy", tx_ready[0], 1);
        td8[0] = 8'h00;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (4 * BC) @(negedge clk);
        check("t6_line_pre", tx_ser[0], 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_line_rst", tx_ser[0], 1);
        check("t6_rdy_rst", tx_ready[0], 0);
        check("t6_rxd_rst", rx_data[0], 0);
        rst = 1'b0;
        repeat (15 * BC) @(negedge clk);
        check("t6_none", rxq.size(), 0);
        tx_frame(0, 9'h07E, 8, 0, 1, BC, "t6");
        expect_rx(0, 9'h07E, 1'b0, 1'b0, "t6_rx");

        for (int k = 0; k < 2; k++) begin
            logic [8:0] w;
            w = 9'($urandom_range(0, 127));
            tx_frame(3, w, 7, 2, 2, BC_S, $sformatf("t7_%0d", k));
            expect_rx(3, w, 1'b0, 1'b0, $sformatf("t7_rx%0d", k));
        end

        repeat (10) @(negedge clk);
        check("tail_none", rxq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
